// File: rtl/inst_mem_sync.sv
// Synchronous-read instruction memory: clears itself after reset, then serves 1-cycle fetches and byte-enabled loader writes.
// Define INST_MEM_PARITY_EN to store a per-word even-parity bit and report mismatches on parity_err_o.
module inst_mem_sync #(
  parameter int              DEPTH    = 1024,
  parameter int              DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_req_i,
  input  logic [31:0]         fetch_addr_i,
  output logic                fetch_ready_o,
  output logic                fetch_valid_o,
  output logic [DATA_W-1:0]   fetch_inst_o,
  output logic                fetch_fault_o,
  input  logic                wr_en_i,
  input  logic [31:0]         wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [DATA_W/8-1:0] wr_be_i,
  output logic                init_done_o,
  output logic                parity_err_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int BE_W  = DATA_W / 8;

  // Handshake: a fetch is taken on any edge where fetch_req_i and fetch_ready_o are
  // both high; its response is a single-cycle fetch_valid_o pulse one edge later.
  typedef enum logic {INIT, RUN} state_t;

  state_t             state;
  logic [IDX_W-1:0]   clr_cnt;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic [IDX_W-1:0]   f_idx;
  logic               f_bad;
  logic               f_accept;
  logic [IDX_W-1:0]   w_idx;
  logic               w_ok;
  logic               unused_wr_lsb;

  assign f_idx    = fetch_addr_i[IDX_W+1:2];
  assign f_bad    = (fetch_addr_i[1:0] != 2'b00) || (fetch_addr_i[31:IDX_W+2] != '0);
  assign f_accept = fetch_req_i && fetch_ready_o;
  assign w_idx    = wr_addr_i[IDX_W+1:2];
  assign w_ok     = wr_en_i && (state == RUN) && (wr_addr_i[31:IDX_W+2] == '0);
  // The loader addresses whole words; its byte offset carries no meaning here.
  assign unused_wr_lsb = ^wr_addr_i[1:0];

`ifdef INST_MEM_PARITY_EN
  logic              par [DEPTH];
  logic [DATA_W-1:0] merged;

  // Parity must cover the word as it will be after a partial write, not just the new bytes.
  always_comb begin
    merged = mem[w_idx];
    for (int b = 0; b < BE_W; b++) begin
      if (wr_be_i[b]) merged[8*b +: 8] = wr_data_i[8*b +: 8];
    end
  end
`else
  assign parity_err_o = 1'b0;
`endif

  // Storage has no reset; INIT zeroes it one word per cycle instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) begin
        mem[clr_cnt] <= '0;
`ifdef INST_MEM_PARITY_EN
        par[clr_cnt] <= 1'b0;
`endif
      end else if (w_ok) begin
        for (int b = 0; b < BE_W; b++) begin
          if (wr_be_i[b]) mem[w_idx][8*b +: 8] <= wr_data_i[8*b +: 8];
        end
`ifdef INST_MEM_PARITY_EN
        par[w_idx] <= ^merged;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= INIT;
      clr_cnt       <= '0;
      fetch_ready_o <= 1'b0;
      fetch_valid_o <= 1'b0;
      fetch_fault_o <= 1'b0;
      fetch_inst_o  <= '0;
      init_done_o   <= 1'b0;
`ifdef INST_MEM_PARITY_EN
      parity_err_o  <= 1'b0;
`endif
    end else begin
      fetch_valid_o <= 1'b0;
      fetch_fault_o <= 1'b0;
`ifdef INST_MEM_PARITY_EN
      parity_err_o  <= 1'b0;
`endif
      case (state)
        INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == IDX_W'(DEPTH - 1)) begin
            state         <= RUN;
            fetch_ready_o <= 1'b1;
            init_done_o   <= 1'b1;
          end
        end
        RUN: begin
          if (f_accept) begin
            fetch_valid_o <= 1'b1;
            if (f_bad) begin
              fetch_fault_o <= 1'b1;
              fetch_inst_o  <= NOP_INST;
            end else begin
              // Read-first: a same-edge loader write lands after this sample.
              fetch_inst_o  <= mem[f_idx];
`ifdef INST_MEM_PARITY_EN
              parity_err_o  <= (^mem[f_idx]) != par[f_idx];
`endif
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_sync.sv
// Self-checking bench for inst_mem_sync: scenario tasks compared against a word-array reference model.
module tb_inst_mem_sync;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req_i = 1'b0;
  logic [31:0] fetch_addr_i = '0;
  logic        fetch_ready_o;
  logic        fetch_valid_o;
  logic [31:0] fetch_inst_o;
  logic        fetch_fault_o;
  logic        wr_en_i = 1'b0;
  logic [31:0] wr_addr_i = '0;
  logic [31:0] wr_data_i = '0;
  logic [3:0]  wr_be_i = '0;
  logic        init_done_o;
  logic        parity_err_o;

  inst_mem_sync #(.DEPTH(DEPTH), .DATA_W(32), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
    .fetch_ready_o(fetch_ready_o), .fetch_valid_o(fetch_valid_o),
    .fetch_inst_o(fetch_inst_o), .fetch_fault_o(fetch_fault_o),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_be_i(wr_be_i),
    .init_done_o(init_done_o), .parity_err_o(parity_err_o)
  );

  always #5 clk = ~clk;

  // Reference model: plain word array plus the expected response of the last cycle.
  logic [31:0] mm [DEPTH];
  logic        exp_valid, exp_fault, exp_perr;
  logic [31:0] exp_inst;
  logic [31:0] last_inst;
  int vectors = 0;
  int miscompares = 0;

  function automatic bit addr_faults(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mm[i] = '0;
    last_inst = '0;
  endtask

  // Driver for one RUN-state cycle; computes the expected response before applying the write.
  task automatic drive(input bit req, input logic [31:0] faddr, input bit wen,
                       input logic [31:0] waddr, input logic [31:0] wdata, input logic [3:0] be);
    fetch_req_i = req; fetch_addr_i = faddr;
    wr_en_i = wen; wr_addr_i = waddr; wr_data_i = wdata; wr_be_i = be;
    exp_perr = 1'b0;
    if (req) begin
      exp_valid = 1'b1;
      exp_fault = addr_faults(faddr);
      exp_inst  = exp_fault ? NOP : mm[faddr / 4];
    end else begin
      exp_valid = 1'b0;
      exp_fault = 1'b0;
      exp_inst  = last_inst;
    end
    if (wen && waddr < 32'(DEPTH * 4)) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mm[waddr / 4][8*b +: 8] = wdata[8*b +: 8];
    end
    @(posedge clk); #1;
    fetch_req_i = 1'b0; wr_en_i = 1'b0;
    last_inst = exp_inst;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({fetch_ready_o, fetch_valid_o, fetch_fault_o, fetch_inst_o, init_done_o, parity_err_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b flt=%b inst=%h done=%b perr=%b, want all 0",
               fetch_ready_o, fetch_valid_o, fetch_fault_o, fetch_inst_o, init_done_o, parity_err_o);
    end
  endtask

  // Releases reset and hammers the ports while INIT runs; nothing may be accepted.
  task automatic test_init(input string tag);
    int rise = -1;
    rst = 1'b0;
    for (int k = 1; k <= 1100 && rise < 0; k++) begin
      fetch_req_i  = 1'($urandom_range(0, 1));
      fetch_addr_i = 32'($urandom_range(0, 31)) << 2;
      wr_en_i      = 1'($urandom_range(0, 1));
      wr_addr_i    = 32'($urandom_range(0, 31)) << 2;
      wr_data_i    = $urandom | 32'h1;
      wr_be_i      = 4'hF;
      @(posedge clk); #1;
      vectors++;
      if (fetch_valid_o !== 1'b0 || fetch_ready_o !== init_done_o) begin
        miscompares++;
        $display("FAIL %s_init_cycle%0d: vld=%b rdy=%b done=%b, want vld=0 rdy==done", tag, k,
                 fetch_valid_o, fetch_ready_o, init_done_o);
      end
      if (fetch_ready_o === 1'b1) rise = k;
    end
    fetch_req_i = 1'b0; wr_en_i = 1'b0;
    vectors++;
    if (rise != DEPTH) begin
      miscompares++;
      $display("FAIL %s_init_len: ready rose after %0d cycles, want %0d", tag, rise, DEPTH);
    end
    model_clear();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 32'(i) << 2, 1'b0, '0, '0, '0);
      vectors++;
      if (fetch_valid_o !== 1'b1 || fetch_inst_o !== 32'h0 || fetch_fault_o !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_cleared_word%0d: vld=%b inst=%h flt=%b, want 1/00000000/0", tag, i,
                 fetch_valid_o, fetch_inst_o, fetch_fault_o);
      end
    end
  endtask

  task automatic test_write_fetch();
    drive(1'b0, '0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    drive(1'b1, 32'h10, 1'b0, '0, '0, '0);
    vectors++;
    if ({fetch_valid_o, fetch_fault_o, fetch_inst_o} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL full_write: vld=%b flt=%b inst=%h, want 1/0/deadbeef", fetch_valid_o, fetch_fault_o, fetch_inst_o);
    end
    drive(1'b0, '0, 1'b0, '0, '0, '0);
    vectors++;
    if ({fetch_valid_o, fetch_fault_o, fetch_inst_o} !== {1'b0, 1'b0, 32'hDEAD_BEEF}) begin
      miscompares++;
      $display("FAIL idle_hold: vld=%b flt=%b inst=%h, want 0/0/deadbeef", fetch_valid_o, fetch_fault_o, fetch_inst_o);
    end
    drive(1'b0, '0, 1'b1, 32'h13, 32'h0000_00AA, 4'b0001);
    drive(1'b1, 32'h10, 1'b0, '0, '0, '0);
    vectors++;
    if (fetch_inst_o !== 32'hDEAD_BEAA) begin
      miscompares++;
      $display("FAIL byte_write: inst=%h, want deadbeaa", fetch_inst_o);
    end
  endtask

  task automatic test_fault();
    logic [31:0] addrs [3];
    addrs[0] = 32'h12; addrs[1] = 32'h1000; addrs[2] = 32'h8000_0004;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, addrs[i], 1'b0, '0, '0, '0);
      vectors++;
      if ({fetch_valid_o, fetch_fault_o, fetch_inst_o} !== {1'b1, 1'b1, NOP}) begin
        miscompares++;
        $display("FAIL fault_%h: vld=%b flt=%b inst=%h, want 1/1/%h", addrs[i],
                 fetch_valid_o, fetch_fault_o, fetch_inst_o, NOP);
      end
    end
    drive(1'b0, '0, 1'b1, 32'h1000, 32'h5555_5555, 4'hF);
    drive(1'b1, 32'h0, 1'b0, '0, '0, '0);
    vectors++;
    if ({fetch_fault_o, fetch_inst_o} !== {1'b0, 32'h0}) begin
      miscompares++;
      $display("FAIL no_alias: flt=%b inst=%h, want 0/00000000", fetch_fault_o, fetch_inst_o);
    end
  endtask

  task automatic test_read_first();
    drive(1'b1, 32'h20, 1'b1, 32'h20, 32'h1111_1111, 4'hF);
    vectors++;
    if (fetch_inst_o !== 32'h0) begin
      miscompares++;
      $display("FAIL read_first_old: inst=%h, want 00000000", fetch_inst_o);
    end
    drive(1'b1, 32'h20, 1'b0, '0, '0, '0);
    vectors++;
    if (fetch_inst_o !== 32'h1111_1111) begin
      miscompares++;
      $display("FAIL read_first_new: inst=%h, want 11111111", fetch_inst_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 32'(i) << 2, 32'hA000_0000 + 32'(i), 4'hF);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(i) << 2, 1'b0, '0, '0, '0);
      vectors++;
      if ({fetch_valid_o, fetch_inst_o} !== {1'b1, 32'hA000_0000 + 32'(i)}) begin
        miscompares++;
        $display("FAIL b2b_%0d: vld=%b inst=%h, want 1/%h", i, fetch_valid_o, fetch_inst_o, 32'hA000_0000 + 32'(i));
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r < 7)  return 32'($urandom_range(0, 31)) << 2;
    if (r == 7) return (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
    if (r == 8) return 32'h1000 + (32'($urandom_range(0, 31)) << 2);
    return $urandom;
  endfunction

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      logic [31:0] wa = rand_addr();
      // Loader ignores the byte offset, so strip faults caused only by misalignment.
      if (wa < 32'(DEPTH * 4) + 32'h100 && $urandom_range(0, 1) == 1) wa = wa & ~32'h3;
      drive(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)), wa, $urandom,
            4'($urandom_range(0, 15)));
      vectors++;
      if ({fetch_valid_o, fetch_fault_o, fetch_inst_o, parity_err_o} !== {exp_valid, exp_fault, exp_inst, exp_perr}) begin
        miscompares++;
        $display("FAIL random_%0d: got vld=%b flt=%b inst=%h perr=%b, want %b/%b/%h/%b", n,
                 fetch_valid_o, fetch_fault_o, fetch_inst_o, parity_err_o,
                 exp_valid, exp_fault, exp_inst, exp_perr);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 32'h10, 1'b0, '0, '0, '0);
    vectors++;
    if (fetch_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_valid: vld=%b, want 1", fetch_valid_o);
    end
    rst = 1'b1; fetch_req_i = 1'b1; fetch_addr_i = 32'h10;
    @(posedge clk); #1;
    fetch_req_i = 1'b0;
    vectors++;
    if ({fetch_valid_o, fetch_ready_o, init_done_o, fetch_inst_o} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: vld=%b rdy=%b done=%b inst=%h, want all 0",
               fetch_valid_o, fetch_ready_o, init_done_o, fetch_inst_o);
    end
    test_init("rerun");
  endtask

  task automatic test_parity();
`ifdef INST_MEM_PARITY_EN
    drive(1'b0, '0, 1'b1, 32'h40, 32'h0F0F_0F0F, 4'hF);
    drive(1'b0, '0, 1'b1, 32'h40, 32'h0000_0070, 4'b0001);
    drive(1'b1, 32'h40, 1'b0, '0, '0, '0);
    vectors++;
    if ({fetch_inst_o, parity_err_o} !== {32'h0F0F_0F70, 1'b0}) begin
      miscompares++;
      $display("FAIL parity_clean: inst=%h perr=%b, want 0f0f0f70/0", fetch_inst_o, parity_err_o);
    end
    dut.mem[16] = dut.mem[16] ^ 32'h1;
    drive(1'b1, 32'h40, 1'b0, '0, '0, '0);
    vectors++;
    if ({fetch_valid_o, fetch_inst_o, parity_err_o} !== {1'b1, 32'h0F0F_0F71, 1'b1}) begin
      miscompares++;
      $display("FAIL parity_flip: vld=%b inst=%h perr=%b, want 1/0f0f0f71/1", fetch_valid_o, fetch_inst_o, parity_err_o);
    end
`else
    drive(1'b0, '0, 1'b1, 32'h40, 32'h0F0F_0F0F, 4'hF);
    drive(1'b1, 32'h40, 1'b0, '0, '0, '0);
    vectors++;
    if ({fetch_inst_o, parity_err_o} !== {32'h0F0F_0F0F, 1'b0}) begin
      miscompares++;
      $display("FAIL parity_tied: inst=%h perr=%b, want 0f0f0f0f/0", fetch_inst_o, parity_err_o);
    end
`endif
  endtask

  initial begin
    model_clear();
    test_reset();
    test_init("first");
    test_write_fetch();
    test_fault();
    test_read_first();
    test_back_to_back();
    test_random();
    test_mid_reset();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
